// File: rtl/tx_uart_fifo.sv
// UART transmitter (8N1, optional even parity, LSB first) fed by a small input FIFO.
// The TX line is registered from the current state, so it trails the FSM by one clk.
module tx_uart_fifo #(
  parameter int CYCLE_PER_BIT = 1302,
  parameter int FIFO_DEPTH    = 4,
  parameter bit PARITY_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data_tx,
  input  logic       in_valid_tx,
  output logic       out_ready_tx,
  output logic       out_serial_tx,
  output logic       out_busy_tx,
  output logic       out_done_tx,
  output logic [4:0] out_fifo_count,
  output logic [2:0] dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(CYCLE_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLE_PER_BIT - 1);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BIT   = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    CLEANUP    = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [4:0]         count;
  logic               push, pop;
  logic [7:0]         shift_q;
  logic               parity_q;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [2:0]         idx, idx_n;
  logic               done_d;
  logic               serial_n;
  logic               bit_end;

  // Handshake: a word is taken on any rising edge where in_valid_tx && out_ready_tx.
  assign out_ready_tx   = (count < DEPTH_C);
  assign push           = in_valid_tx && out_ready_tx;
  assign bit_end        = (bit_cnt == LAST_CNT);
  assign out_fifo_count = count;
  assign out_busy_tx    = (state != IDLE);
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data_tx;
  end

  // Count kept apart from the pointers so full and empty are never ambiguous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    idx_n     = idx;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        idx_n     = '0;
        if (count != 5'd0) begin
          pop     = 1'b1;
          state_n = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = DATA_BIT;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      DATA_BIT: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          idx_n     = idx + 3'd1;
          if (idx == 3'd7) state_n = PARITY_EN ? PARITY_BIT : STOP_BIT;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      PARITY_BIT: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = STOP_BIT;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          done_d    = 1'b1;
          state_n   = CLEANUP;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      CLEANUP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    serial_n = 1'b1;
    case (state)
      START_BIT:  serial_n = 1'b0;
      DATA_BIT:   serial_n = shift_q[idx];
      PARITY_BIT: serial_n = parity_q;
      default:    serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      idx           <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      out_serial_tx <= 1'b1;
      out_done_tx   <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      idx           <= idx_n;
      out_serial_tx <= serial_n;
      out_done_tx   <= done_d;
      // The frame owns its own copy, so later input changes cannot disturb it.
      if (pop) begin
        shift_q  <= mem[rd_ptr];
        parity_q <= ^mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_tx_uart_fifo.sv
// Bench for tx_uart_fifo: one instance without parity, one with even parity, both at 8 clks/bit.
// Frames are decoded from the line mid-bit and checked against a queue of accepted words.
module tb_tx_uart_fifo;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1, serial0, serial1, busy0, busy1, done0, done1;
  logic [4:0] count0, count1;
  logic [2:0] state0, state1;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         fall_q0[$];
  int         fall_q1[$];
  int         cyc = 0;
  int         done_hi0 = 0;
  int         done_hi1 = 0;
  int         checks = 0;
  int         errors = 0;
  bit         abort0 = 1'b0;

  tx_uart_fifo #(.CYCLE_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data_tx(data0), .in_valid_tx(valid0),
    .out_ready_tx(ready0), .out_serial_tx(serial0), .out_busy_tx(busy0),
    .out_done_tx(done0), .out_fifo_count(count0), .dbg_state(state0)
  );

  tx_uart_fifo #(.CYCLE_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data_tx(data1), .in_valid_tx(valid1),
    .out_ready_tx(ready1), .out_serial_tx(serial1), .out_busy_tx(busy1),
    .out_done_tx(done1), .out_fifo_count(count1), .dbg_state(state1)
  );

  // Clock / cycle counter / done-pulse counters
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done0 === 1'b1) done_hi0++;
    if (done1 === 1'b1) done_hi1++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int u);
    return (u == 0) ? serial0 : serial1;
  endfunction

  // Frame decoder: start seen at the first low negedge, then samples 3.5 clks into each bit.
  task automatic monitor(input int u);
    logic [7:0] d;
    logic [7:0] w;
    logic       s, p, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && line(u) === 1'b0) begin
        if (u == 0) fall_q0.push_back(cyc); else fall_q1.push_back(cyc);
        p = 1'b0;
        repeat (3) @(negedge clk);
        s = line(u);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = line(u);
        end
        if (u == 1) begin
          repeat (CPB) @(negedge clk);
          p = line(u);
        end
        repeat (CPB) @(negedge clk);
        e = line(u);
        if (u == 0 && abort0) begin
          abort0 = 1'b0;
        end else begin
          check($sformatf("frame_expected%0d", u),
                (u == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0), 1'b1);
          if ((u == 0 && exp_q0.size() > 0) || (u == 1 && exp_q1.size() > 0)) begin
            w = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("start_bit%0d", u), s, 1'b0);
            check($sformatf("data%0d", u), d, w);
            check($sformatf("stop_bit%0d", u), e, 1'b1);
            if (u == 1) check("parity_bit", p, ^w);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Driver: offers a word before the next edge; acc is whether it must be accepted there.
  task automatic drive(input int u, input logic [7:0] d, input logic acc);
    @(negedge clk);
    if (u == 0) begin
      data0 = d; valid0 = 1'b1;
      check("ready0", ready0, acc);
      if (acc) exp_q0.push_back(d);
    end else begin
      data1 = d; valid1 = 1'b1;
      check("ready1", ready1, acc);
      if (acc) exp_q1.push_back(d);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    valid0 = 1'b0; data0 = $urandom_range(0, 255);
    valid1 = 1'b0; data1 = $urandom_range(0, 255);
  endtask

  task automatic wait_drain(input int u, input int budget);
    int n;
    n = 0;
    while (n < budget && ((u == 0) ? (exp_q0.size() != 0 || busy0 !== 1'b0)
                                   : (exp_q1.size() != 0 || busy1 !== 1'b0))) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain%0d", u), n < budget, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t0;
    int base;
    int nf;
    rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0; data0 = 8'h00; data1 = 8'h00;

    // 1: reset values, then 50 idle clks
    repeat (3) @(negedge clk);
    check("rst_serial", serial0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_count", count0, 5'd0);
    check("rst_ready", ready0, 1'b1);
    check("rst_state", state0, 3'd0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_serial", serial0, 1'b1);
    check("idle_ready", ready0, 1'b1);
    check("idle_count", count0, 5'd0);
    check("idle_busy", busy0, 1'b0);
    check("idle_serial1", serial1, 1'b1);

    // 2: single word; pushed at the coming edge N, line low from edge N+2
    drive(0, 8'hA5, 1'b1);
    t0 = cyc;
    idle_in();
    wait_drain(0, 300);
    check("frames_a5", fall_q0.size(), 1);
    if (fall_q0.size() == 1) check("latency", fall_q0[0] - t0, 3);
    check("done_pulse_a5", done_hi0, 1);

    // 3: burst into an empty FIFO. The second edge also pops, so five words fit
    // and the sixth meets a full FIFO and is dropped.
    base = fall_q0.size();
    drive(0, 8'h00, 1'b1);
    drive(0, 8'h55, 1'b1);
    drive(0, 8'hFF, 1'b1);
    drive(0, 8'h3C, 1'b1);
    drive(0, 8'h96, 1'b1);
    drive(0, 8'h69, 1'b0);
    check("full_count", count0, 5'd4);
    idle_in();
    wait_drain(0, 1000);
    check("frames_burst", fall_q0.size() - base, 5);
    for (int i = base + 1; i < fall_q0.size(); i++)
      check("b2b_spacing", fall_q0[i] - fall_q0[i-1], 10 * CPB + 2);
    check("done_pulses_burst", done_hi0, 6);

    // 4: even parity; back-to-back start spacing = 11*8 frame + 2 gap clks
    drive(1, 8'h07, 1'b1);
    drive(1, 8'h03, 1'b1);
    idle_in();
    wait_drain(1, 400);
    check("frames_parity", fall_q1.size(), 2);
    if (fall_q1.size() == 2) check("parity_spacing", fall_q1[1] - fall_q1[0], 11 * CPB + 2);
    check("done_pulses_parity", done_hi1, 2);

    // 5: reset during data bit 0 of 0xF0 with two words queued
    drive(0, 8'hF0, 1'b1);
    idle_in();
    repeat (12) @(negedge clk);
    drive(0, 8'h11, 1'b1);
    drive(0, 8'h22, 1'b1);
    idle_in();
    check("pre_rst_count", count0, 5'd2);
    check("pre_rst_state", state0, 3'd2);
    check("pre_rst_line", serial0, 1'b0);
    #2;
    rst = 1'b0;
    abort0 = 1'b1;
    exp_q0.delete();
    #1;
    check("abort_line", serial0, 1'b1);
    check("abort_count", count0, 5'd0);
    check("abort_busy", busy0, 1'b0);
    check("abort_ready", ready0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nf = fall_q0.size();
    repeat (100) @(negedge clk);
    check("no_frame_after_rst", fall_q0.size(), nf);
    check("post_rst_line", serial0, 1'b1);
    check("post_rst_count", count0, 5'd0);
    check("post_rst_state", state0, 3'd0);
    check("abort_consumed", abort0, 1'b0);

    // 6: second push lands on the edge where IDLE pops the first
    base = fall_q0.size();
    drive(0, 8'h81, 1'b1);
    drive(0, 8'h42, 1'b1);
    idle_in();
    check("push_pop_count", count0, 5'd1);
    wait_drain(0, 400);
    check("frames_push_pop", fall_q0.size() - base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
